ahb_sram_slave: RTL and testbench



---
 rtl/ahb_sram_slave.sv | 145 ++++++++++++++
 tb/tb_ahb_sram_slave.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/ahb_sram_slave.sv
`default_nettype none
// ============================================================================
// Module      : ahb_sram_slave
// Description : AHB-Lite responder around a word-organised on-chip SRAM with
//               programmable wait states and the two-cycle ERROR response for
//               misaligned or oversized transfers.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_sram_slave #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        i_hclk,
    input  logic        i_hreset,
    input  logic        i_hsel,
    input  logic [31:0] i_haddr,
    input  logic [1:0]  i_htrans,
    input  logic        i_hwrite,
    input  logic [2:0]  i_hsize,
    input  logic [31:0] i_hwdata,
    input  logic        i_hready,
    output logic        o_hreadyout,
    output logic [1:0]  o_hresp,
    output logic [31:0] o_hrdata
);

    localparam int         c_DEPTH = 1 << ADDR_WIDTH;
    localparam logic [3:0] c_WAIT  = 4'(WAIT_STATES);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_DONE = 3'd2,
        S_ERR1 = 3'd3,
        S_ERR2 = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [3:0]              r_cnt;
    logic [3:0]              w_cnt_next;
    logic                    r_hreadyout;
    logic [1:0]              r_hresp;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic                    r_write;
    logic [3:0]              r_be;
    logic [3:0]              w_be;
    logic                    w_legal;
    logic                    w_accept;
    logic [31:0]             r_mem [0:c_DEPTH-1];

    // Upper address bits alias by design; HTRANS[0] (SEQ vs NONSEQ) is irrelevant here
    logic w_unused;
    assign w_unused = &{1'b0, i_haddr[31:ADDR_WIDTH+2], i_htrans[0]};

    // A new address phase is only taken while no data phase is holding the bus
    assign w_accept = i_hsel && i_htrans[1] && i_hready &&
                      (r_state != S_WAIT) && (r_state != S_ERR1);

    assign w_legal = (i_hsize == 3'd0) ||
                     ((i_hsize == 3'd1) && !i_haddr[0]) ||
                     ((i_hsize == 3'd2) && (i_haddr[1:0] == 2'b00));

    // Little-endian byte-lane enables from size and low address bits
    always_comb begin
        w_be = 4'b0000;
        case (i_hsize)
            3'd0:    w_be = 4'b0001 << i_haddr[1:0];
            3'd1:    w_be = i_haddr[1] ? 4'b1100 : 4'b0011;
            3'd2:    w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    // Next-state and wait-counter logic
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            S_WAIT: begin
                if (r_cnt <= 4'd1) begin
                    w_next     = S_DONE;
                    w_cnt_next = 4'd0;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            S_ERR1: w_next = S_ERR2;
            default: begin
                if (w_accept) begin
                    if (!w_legal) begin
                        w_next = S_ERR1;
                    end else if (c_WAIT != 4'd0) begin
                        w_next     = S_WAIT;
                        w_cnt_next = c_WAIT;
                    end else begin
                        w_next = S_DONE;
                    end
                end else begin
                    w_next = S_IDLE;
                end
            end
        endcase
    end

    // FSM state, counter, registered response outputs and captured address phase
    always_ff @(posedge i_hclk or posedge i_hreset) begin
        if (i_hreset) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_hreadyout <= 1'b1;
            r_hresp     <= 2'b00;
            r_addr      <= '0;
            r_write     <= 1'b0;
            r_be        <= 4'b0000;
        end else begin
            r_state     <= w_next;
            r_cnt       <= w_cnt_next;
            r_hreadyout <= (w_next != S_WAIT) && (w_next != S_ERR1);
            r_hresp     <= ((w_next == S_ERR1) || (w_next == S_ERR2)) ? 2'b01 : 2'b00;
            if (w_accept) begin
                r_addr  <= i_haddr[ADDR_WIDTH+1:2];
                r_write <= i_hwrite;
                r_be    <= w_be;
            end
        end
    end

    // Write commits at the edge closing DONE, using the data-phase HWDATA lanes
    always_ff @(posedge i_hclk) begin
        if ((r_state == S_DONE) && r_write) begin
            for (int i = 0; i < 4; i++) begin
                if (r_be[i]) begin
                    r_mem[r_addr][8*i +: 8] <= i_hwdata[8*i +: 8];
                end
            end
        end
    end

    assign o_hreadyout = r_hreadyout;
    assign o_hresp     = r_hresp;
    assign o_hrdata    = ((r_state == S_DONE) && !r_write) ? r_mem[r_addr] : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_ahb_sram_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_sram_slave
// Description : Directed self-checking bench for ahb_sram_slave. One instance
//               runs with one wait state, a second with zero wait states.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_sram_slave;

    logic        clk;
    logic        rst;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        stall;
    logic        use0;

    wire         ro1, ro0;
    wire [1:0]   resp1, resp0;
    wire [31:0]  rd1, rd0;
    wire         hready;
    wire         w_ro;
    wire [1:0]   w_resp;
    wire [31:0]  w_rd;

    int checks = 0;
    int errors = 0;

    // Global HREADY: another slave may hold it low via stall
    assign hready = ~stall & ro0 & ro1;
    assign w_ro   = use0 ? ro0   : ro1;
    assign w_resp = use0 ? resp0 : resp1;
    assign w_rd   = use0 ? rd0   : rd1;

    ahb_sram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(1)) dut1 (
        .i_hclk(clk), .i_hreset(rst), .i_hsel(hsel & ~use0), .i_haddr(haddr),
        .i_htrans(htrans), .i_hwrite(hwrite), .i_hsize(hsize), .i_hwdata(hwdata),
        .i_hready(hready), .o_hreadyout(ro1), .o_hresp(resp1), .o_hrdata(rd1)
    );

    ahb_sram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(0)) dut0 (
        .i_hclk(clk), .i_hreset(rst), .i_hsel(hsel & use0), .i_haddr(haddr),
        .i_htrans(htrans), .i_hwrite(hwrite), .i_hsize(hsize), .i_hwdata(hwdata),
        .i_hready(hready), .o_hreadyout(ro0), .o_hresp(resp0), .o_hrdata(rd0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One non-overlapped transfer; called just after a rising edge
    task automatic xfer(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] wd, input int exp_low, input logic exp_err,
                        input logic [31:0] exp_rd, input string tag);
        int low;
        hsel   = 1'b1;
        htrans = 2'b10;
        hwrite = wr;
        haddr  = a;
        hsize  = sz;
        @(posedge clk); #1;
        hsel   = 1'b0;
        htrans = 2'b00;
        hwdata = wd;
        low    = 0;
        @(negedge clk);
        while (w_ro !== 1'b1 && low < 20) begin
            check({tag, "_lowresp"}, {30'd0, w_resp}, exp_err ? 32'd1 : 32'd0);
            low++;
            @(negedge clk);
        end
        check({tag, "_lowcycles"}, low, exp_low);
        check({tag, "_resp"}, {30'd0, w_resp}, exp_err ? 32'd1 : 32'd0);
        if (!wr && !exp_err) check({tag, "_rdata"}, w_rd, exp_rd);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; hsel = 1'b0; haddr = 32'h0; htrans = 2'b00; hwrite = 1'b0;
        hsize = 3'd2; hwdata = 32'h0; stall = 1'b0; use0 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready1", {31'd0, ro1}, 32'd1);
        check("rst_resp1",  {30'd0, resp1}, 32'd0);
        check("rst_rdata1", rd1, 32'd0);
        check("rst_ready0", {31'd0, ro0}, 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        // Word write then read, one wait state each
        xfer(1'b1, 32'h10, 3'd2, 32'hDEADBEEF, 1, 1'b0, 32'h0, "wr_word");
        xfer(1'b0, 32'h10, 3'd2, 32'h0, 1, 1'b0, 32'hDEADBEEF, "rd_word");

        // Byte and halfword lane merging
        xfer(1'b1, 32'h10, 3'd2, 32'h11223344, 1, 1'b0, 32'h0, "wr_base");
        xfer(1'b1, 32'h13, 3'd0, 32'hAA000000, 1, 1'b0, 32'h0, "wr_byte");
        xfer(1'b0, 32'h10, 3'd2, 32'h0, 1, 1'b0, 32'hAA223344, "rd_byte");
        xfer(1'b1, 32'h10, 3'd1, 32'h00005566, 1, 1'b0, 32'h0, "wr_half");
        xfer(1'b0, 32'h10, 3'd2, 32'h0, 1, 1'b0, 32'hAA225566, "rd_half");

        // Illegal transfers: two-cycle ERROR, memory untouched
        xfer(1'b1, 32'h00, 3'd2, 32'h00000000, 1, 1'b0, 32'h0, "wr_zero");
        xfer(1'b1, 32'h02, 3'd2, 32'hFFFFFFFF, 1, 1'b1, 32'h0, "err_word");
        xfer(1'b1, 32'h01, 3'd1, 32'hFFFFFFFF, 1, 1'b1, 32'h0, "err_half");
        xfer(1'b1, 32'h10, 3'd3, 32'hFFFFFFFF, 1, 1'b1, 32'h0, "err_size");
        xfer(1'b0, 32'h00, 3'd2, 32'h0, 1, 1'b0, 32'h00000000, "rd_after_err0");
        xfer(1'b0, 32'h10, 3'd2, 32'h0, 1, 1'b0, 32'hAA225566, "rd_after_err10");

        // Zero wait states, back-to-back write then read of the same word
        use0 = 1'b1;
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h20; hsize = 3'd2;
        @(posedge clk); #1;
        hwdata = 32'h1; hwrite = 1'b0; haddr = 32'h20;
        @(negedge clk);
        check("b2b_wr_ready", {31'd0, ro0}, 32'd1);
        check("b2b_wr_resp",  {30'd0, resp0}, 32'd0);
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00;
        @(negedge clk);
        check("b2b_rd_ready", {31'd0, ro0}, 32'd1);
        check("b2b_rd_data",  rd0, 32'h1);
        @(posedge clk); #1;
        xfer(1'b0, 32'h20, 3'd2, 32'h0, 0, 1'b0, 32'h1, "ws0_rd");
        use0 = 1'b0;

        // Bus stalled by another slave: no accept
        stall = 1'b1;
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h40; hsize = 3'd2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_ready", {31'd0, ro1}, 32'd1);
            @(posedge clk); #1;
        end
        hsel = 1'b0; htrans = 2'b00; stall = 1'b0;
        @(negedge clk);
        check("stall_no_accept", {31'd0, ro1}, 32'd1);
        @(posedge clk); #1;

        // Reset during the wait cycle of a write drops the write
        xfer(1'b1, 32'h30, 3'd2, 32'h00000000, 1, 1'b0, 32'h0, "wr_30_zero");
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h30; hsize = 3'd2;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; hwdata = 32'hFFFFFFFF;
        @(negedge clk);
        check("mid_wait_ready", {31'd0, ro1}, 32'd0);
        #1 rst = 1'b1;
        #1;
        check("async_rst_ready", {31'd0, ro1}, 32'd1);
        check("async_rst_resp",  {30'd0, resp1}, 32'd0);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        xfer(1'b0, 32'h30, 3'd2, 32'h0, 1, 1'b0, 32'h00000000, "rd_30_after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
